// File: rtl/pipelined_rca_adder.sv
// Elastic pipelined ripple-carry adder/subtractor: one CW-bit carry chunk resolved per stage.
// Optional build macro RCA_SATURATE_EN clamps the result to the signed limit on overflow.
module pipelined_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                            input logic ci);
    return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
  endfunction

`ifdef RCA_SATURATE_EN
  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] s,
                                                       input logic ov, input logic a_msb);
    if (!ov) return s;
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  logic [STAGES-1:0] vld_p, adv, take, load;
  logic [STAGES-1:0] c_p, src_c, nxt_c;
  logic [WIDTH-1:0]  a_p   [STAGES];
  logic [WIDTH-1:0]  b_p   [STAGES];
  logic [WIDTH-1:0]  s_p   [STAGES];
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [WIDTH-1:0]  fin_s;
  logic [CW:0]       chunk;
  logic              ovf_p, nxt_ovf, msb_cin, ds;

  // Handshake: readiness ripples back from out_ready so a full pipe still moves every cycle.
  always_comb begin
    ds   = out_ready;
    adv  = '0;
    take = '0;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]  = vld_p[k] && ds;
      take[k] = !vld_p[k] || ds;
      ds      = take[k];
    end
    load[0] = in_valid && take[0];
    for (int k = 1; k < STAGES; k++) load[k] = adv[k-1];
  end

  assign in_ready = take[0];

  // Datapath: stage k consumes chunk k of its predecessor's operands and carry.
  always_comb begin
    src_a[0] = a;
    src_b[0] = op ? ~b : b;
    src_c[0] = op ? 1'b1 : cin;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_p[k-1];
      src_b[k] = b_p[k-1];
      src_c[k] = c_p[k-1];
      src_s[k] = s_p[k-1];
    end
    chunk = '0;
    nxt_c = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk                 = add_chunk(src_a[k][k*CW +: CW], src_b[k][k*CW +: CW], src_c[k]);
      nxt_s[k]              = src_s[k];
      nxt_s[k][k*CW +: CW]  = chunk[CW-1:0];
      nxt_c[k]              = chunk[CW];
    end
    msb_cin = src_a[L][WIDTH-1] ^ src_b[L][WIDTH-1] ^ nxt_s[L][WIDTH-1];
    nxt_ovf = msb_cin ^ nxt_c[L];
`ifdef RCA_SATURATE_EN
    fin_s = saturate(nxt_s[L], nxt_ovf, src_a[L][WIDTH-1]);
`else
    fin_s = nxt_s[L];
`endif
  end

  // Stage registers: data only moves on load so a stalled stage holds its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      c_p   <= '0;
      ovf_p <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_p[k] <= '0;
        b_p[k] <= '0;
        s_p[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld_p[k] <= 1'b1;
          a_p[k]   <= src_a[k];
          b_p[k]   <= src_b[k];
          c_p[k]   <= nxt_c[k];
          s_p[k]   <= (k == L) ? fin_s : nxt_s[k];
        end else if (adv[k]) begin
          vld_p[k] <= 1'b0;
        end
      end
      if (load[L]) ovf_p <= nxt_ovf;
    end
  end

  assign out_valid = vld_p[L];
  assign sum       = s_p[L];
  assign c_out     = c_p[L];
  assign ovf       = ovf_p;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Bench for pipelined_rca_adder (WIDTH=16, STAGES=4): directed corner cases, reset, backpressure
// and a long random stream scored against a signed-integer reference model.
module tb_pipelined_rca_adder;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, op, out_valid, out_ready, c_out, ovf;
  logic [W-1:0] a, b, sum;

  int n_cmp = 0;
  int n_err = 0;
  int popped = 0;
  logic         acc;
  logic [W+1:0] q[$];
  logic         hold_pending = 1'b0;
  logic [W+1:0] hold_val;

  pipelined_rca_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: true signed result range decides overflow; unsigned compare decides carry.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic o);
    int sx, sy, res;
    logic carry, ov;
    logic [W-1:0] s;
    sx = $signed(x);
    sy = $signed(y);
    if (o) begin
      res   = sx - sy;
      carry = (x >= y);
    end else begin
      res   = sx + sy + int'(ci);
      carry = (int'(x) + int'(y) + int'(ci)) > 65535;
    end
    ov = (res > 32767) || (res < -32768);
    s  = res[W-1:0];
`ifdef RCA_SATURATE_EN
    if (res > 32767) s = 16'h7FFF;
    else if (res < -32768) s = 16'h8000;
`endif
    return {ov, carry, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle at negedge, score handshakes, then advance past the rising edge.
  task automatic cycle();
    logic [W+1:0] e;
    @(negedge clk);
    if (hold_pending) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'({ovf, c_out, sum}), 32'(hold_val));
    end
    chk("in_ready", 32'(in_ready), 32'((q.size() < S) || out_ready));
    if (q.size() == 0) chk("no_stale", 32'(out_valid), 32'd0);
    if (out_valid && out_ready && q.size() > 0) begin
      e = q.pop_front();
      popped++;
      chk("result", 32'({ovf, c_out, sum}), 32'(e));
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(ref_op(a, b, cin, op));
    hold_pending = out_valid && !out_ready;
    hold_val     = {ovf, c_out, sum};
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic ci, input logic o, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    a = xa; b = xb; cin = ci; op = o; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (S - 2) cycle();
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    cycle();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(c_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    int sent;
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", 32'({c_out, ovf}), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("chunk_carry", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
`ifdef RCA_SATURATE_EN
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
    directed("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    cycle();

    // Reset with three operations in flight: everything must vanish immediately.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_flags", 32'({c_out, ovf}), 32'd0);
    q.delete();
    hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    repeat (S + 4) cycle();

    // Backpressure: eight back-to-back operations with the sink stalled for a while.
    sent = 0;
    base = popped;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (sent < 8);
      out_ready = !(c >= 2 && c <= 10);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 1'($urandom);
      cycle();
      if (acc) sent++;
    end
    chk("bp_sent", 32'(sent), 32'd8);
    chk("bp_drained", 32'(popped - base), 32'd8);
    chk("bp_empty", 32'(q.size()), 32'd0);

    // Random stream with random handshakes on both sides.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 1'($urandom);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 2) cycle();
    chk("rand_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
